// File: rtl/boot_selector.sv
// Boot image selector: a button picks one of N_IMG warm-boot images, pre-boot tasks run under a
// per-task watchdog, then a held BOOT request is raised for SB_WARMBOOT.
module boot_selector #(
  parameter int                 N_IMG       = 4,
  parameter int                 DEF_IMG     = 2,
  parameter int                 SEL_IMG     = 1,
  parameter int                 TMO_BIT     = 23,
  parameter int                 REARM_BIT   = 17,
  parameter int                 LONG_BIT    = 24,
  parameter int                 N_TASKS     = 2,
  parameter logic [N_TASKS-1:0] SKIP_MASK   = '1,
  parameter int                 TASK_TO_BIT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn,
  output logic [N_TASKS-1:0] task_go,
  input  logic [N_TASKS-1:0] task_rdy,
  output logic [N_TASKS-1:0] task_err,
  output logic [1:0]         boot_sel,
  output logic               boot_now,
  output logic [3:0]         led_flash_cnt,
  output logic               skip
);

  typedef enum logic [2:0] {START, WAIT_REL, SEL, SEL_WAIT, TASK, BOOT} state_t;

  state_t               state, state_nxt;
  logic [TMO_BIT:0]     timer;
  logic [LONG_BIT:0]    hold;
  logic [TASK_TO_BIT:0] wdog;
  logic [2:0]           idx, idx_nxt;
  logic                 btn_q;
  logic [1:0]           sel_nxt;
  logic                 skip_nxt;
  logic [N_TASKS-1:0]   err_nxt;
  logic                 advance;

  logic               rise, in_sel, long_press, tick;
  logic [N_TASKS-1:0] cur_mask;
  logic               task_first, bypass, cur_rdy, last_task;

  assign rise       = btn & ~btn_q;
  assign in_sel     = (state == SEL) || (state == SEL_WAIT);
  assign long_press = in_sel && hold[LONG_BIT];
  assign tick       = ((state == SEL) && timer[TMO_BIT]) ||
                      ((state == SEL_WAIT) && timer[REARM_BIT]);
  assign cur_mask   = N_TASKS'(1) << idx;
  // The watchdog only reads zero in the first cycle of a task, so it doubles as the start marker.
  assign task_first = (wdog == '0);
  assign bypass     = skip && |(SKIP_MASK & cur_mask);
  assign cur_rdy    = |(task_rdy & cur_mask);
  assign last_task  = (idx == 3'(N_TASKS - 1));

  assign led_flash_cnt = {2'b00, boot_sel} + 4'd1;

  always_comb begin
    state_nxt = state;
    sel_nxt   = boot_sel;
    skip_nxt  = skip;
    idx_nxt   = idx;
    err_nxt   = task_err;
    advance   = 1'b0;
    task_go   = '0;
    case (state)
      START: begin
        idx_nxt = 3'd0;
        if (btn) begin
          state_nxt = WAIT_REL;
          sel_nxt   = 2'(SEL_IMG);
        end else begin
          state_nxt = TASK;
          sel_nxt   = 2'(DEF_IMG);
        end
      end
      WAIT_REL: begin
        if (!btn) state_nxt = SEL_WAIT;
      end
      SEL: begin
        if (long_press) begin
          state_nxt = TASK;
        end else if (rise) begin
          // A press wins over a timeout landing in the same cycle.
          sel_nxt   = (boot_sel == 2'(N_IMG - 1)) ? 2'd0 : boot_sel + 2'd1;
          if (boot_sel == 2'd0) skip_nxt = 1'b1;
          state_nxt = SEL_WAIT;
        end else if (timer[TMO_BIT]) begin
          state_nxt = TASK;
        end
      end
      SEL_WAIT: begin
        if (long_press)            state_nxt = TASK;
        else if (timer[REARM_BIT]) state_nxt = SEL;
      end
      TASK: begin
        if (task_first) begin
          if (bypass) advance = 1'b1;
          else        task_go = cur_mask;
        end else if (cur_rdy) begin
          advance = 1'b1;
        end else if (wdog[TASK_TO_BIT]) begin
          err_nxt = task_err | cur_mask;
          advance = 1'b1;
        end
        if (advance) begin
          if (last_task) state_nxt = BOOT;
          else           idx_nxt   = idx + 3'd1;
        end
      end
      BOOT: begin
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= START;
      boot_sel <= 2'(DEF_IMG);
      skip     <= 1'b0;
      task_err <= '0;
      idx      <= 3'd0;
      btn_q    <= 1'b0;
      timer    <= '0;
      hold     <= '0;
      wdog     <= '0;
      boot_now <= 1'b0;
    end else begin
      state    <= state_nxt;
      boot_sel <= sel_nxt;
      skip     <= skip_nxt;
      task_err <= err_nxt;
      idx      <= idx_nxt;
      btn_q    <= btn;
      timer    <= (btn || tick) ? '0 : timer + 1'b1;
      hold     <= (in_sel && btn) ? hold + 1'b1 : '0;
      wdog     <= ((state == TASK) && !advance) ? wdog + 1'b1 : '0;
      boot_now <= (state == BOOT);
    end
  end

endmodule

// File: tb/tb_boot_selector.sv
// Randomized bench for boot_selector: press sequences and task latencies are scored against
// a timing/selection model derived from the button, timeout and watchdog rules.
module tb_boot_selector;

  localparam int NT    = 2;
  localparam int DEF   = 2;
  localparam int SELI  = 1;
  localparam int NIMG  = 4;
  localparam int TMO   = 64;   // 2**TMO_BIT
  localparam int REARM = 8;    // 2**REARM_BIT
  localparam int LONG  = 128;  // 2**LONG_BIT
  localparam int WD    = 16;   // 2**TASK_TO_BIT

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          btn = 1'b0;
  logic [NT-1:0] task_rdy = '0;
  logic [NT-1:0] task_go, task_err;
  logic [1:0]    boot_sel;
  logic          boot_now, skip;
  logic [3:0]    led_flash_cnt;

  boot_selector #(
    .N_IMG(NIMG), .DEF_IMG(DEF), .SEL_IMG(SELI), .TMO_BIT(6), .REARM_BIT(3),
    .LONG_BIT(7), .N_TASKS(NT), .SKIP_MASK(2'b11), .TASK_TO_BIT(4)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .task_go(task_go), .task_rdy(task_rdy),
    .task_err(task_err), .boot_sel(boot_sel), .boot_now(boot_now),
    .led_flash_cnt(led_flash_cnt), .skip(skip)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".task_go"},  task_go,       0);
    chk({tag, ".boot_now"}, boot_now,      0);
    chk({tag, ".boot_sel"}, boot_sel,      DEF);
    chk({tag, ".skip"},     skip,          0);
    chk({tag, ".task_err"}, task_err,      0);
    chk({tag, ".led"},      led_flash_cnt, DEF + 1);
  endtask

  // Latencies above WD mean the task never reports ready.
  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 40;
    if (r == 1) return WD;
    if (r == 2) return WD + 1;
    return $urandom_range(1, WD - 1);
  endfunction

  // e0: cycle in which the first task's first cycle is visible. abort_kind 1/2 resets mid-go / mid-boot.
  task automatic run_boot(input int e0, input int lat0, input int lat1, input logic skp,
                          input logic [1:0] exp_sel, input int hold_until, input int abort_kind);
    int lat[NT];
    int gc[NT], rc[NT], endc[NT];
    int e, bc;
    logic [NT-1:0] exp_err, eg, nz;
    lat[0] = lat0;
    lat[1] = lat1;
    e = e0;
    exp_err = '0;
    for (int i = 0; i < NT; i++) begin
      if (skp) begin
        gc[i] = -1; rc[i] = -1; e += 1;
      end else begin
        gc[i] = e;
        if (lat[i] <= WD) begin
          rc[i] = e + lat[i]; e += lat[i] + 1;
        end else begin
          rc[i] = -1; exp_err[i] = 1'b1; e += WD + 1;
        end
      end
      endc[i] = e;
    end
    bc = e + 1;
    while (cyc <= bc + 3) begin
      btn = (cyc < hold_until) ? 1'b1 : (cyc >= e0) ? 1'($urandom) : 1'b0;
      for (int j = 0; j < NT; j++) begin
        eg[j] = (cyc == gc[j]);
        nz[j] = (cyc < e0 || cyc >= endc[j]) ? 1'($urandom) : 1'b0;
        task_rdy[j] = (cyc == rc[j]) | nz[j];
      end
      if (task_go != '0 || eg != '0) chk("task_go", task_go, eg);
      if (cyc >= bc - 1) chk("boot_now", boot_now, int'(cyc >= bc));
      if (abort_kind == 1 && cyc == gc[0]) begin
        rst = 1'b1; #1;
        check_reset_vals("abort_task");
        return;
      end
      if (abort_kind == 2 && cyc == bc + 1) begin
        rst = 1'b1; #1;
        check_reset_vals("abort_boot");
        return;
      end
      @(negedge clk);
    end
    chk("task_err", task_err, exp_err);
    chk("boot_sel", boot_sel, exp_sel);
    chk("led",      led_flash_cnt, exp_sel + 1);
    chk("skip",     skip, skp);
  endtask

  // mode 0: button released at start; 1: short presses; 2: short presses then a final long press.
  task automatic scenario(input int mode, input int npress, input int lat0, input int lat1,
                          input int abort_kind);
    int r, pc, hold_until, e0;
    logic [1:0] sel;
    logic skp;
    rst = 1'b1;
    btn = (mode != 0);
    task_rdy = '0;
    hold_until = 0;
    pc = 0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    r = cyc;
    sel = 2'(DEF);
    skp = 1'b0;
    if (mode == 0) begin
      e0 = r + 1;
    end else begin
      repeat ($urandom_range(2, 8)) @(negedge clk);
      chk("sel_preset", boot_sel, SELI);
      sel = 2'(SELI);
      btn = 1'b0;
      r = cyc;
      for (int p = 0; p < npress; p++) begin
        repeat ($urandom_range(12, 40)) @(negedge clk);
        btn = 1'b1;
        pc = cyc;
        if (sel == 2'd0) skp = 1'b1;
        sel = 2'((sel + 1) % NIMG);
        @(negedge clk);
        chk("sel_step",  boot_sel, sel);
        chk("skip_step", skip, skp);
        if (mode == 2 && p == npress - 1) begin
          hold_until = pc + LONG + 12;
          break;
        end
        repeat ($urandom_range(0, 19)) @(negedge clk);
        btn = 1'b0;
        r = cyc;
      end
      // Release -> rearm tick -> select-mode timeout; a long press ends after LONG held cycles.
      e0 = (mode == 2) ? pc + LONG + 1 : r + REARM + 1 + TMO + 1;
    end
    run_boot(e0, lat0, lat1, skp, sel, hold_until, abort_kind);
  endtask

  initial begin
    int m, np;
    scenario(0, 0, 3, 5, 0);
    scenario(1, 2, 2, 2, 0);
    scenario(1, 4, 3, 3, 0);
    scenario(2, 1, 4, 2, 0);
    scenario(0, 0, 40, 4, 0);
    scenario(0, 0, WD, 1, 0);
    scenario(0, 0, 1, WD + 1, 0);
    scenario(0, 0, 2, 3, 1);
    scenario(0, 0, 2, 2, 0);
    scenario(1, 1, 2, 3, 2);
    scenario(2, 5, 1, 1, 0);
    for (int it = 0; it < 12; it++) begin
      m  = $urandom_range(0, 2);
      np = (m == 2) ? $urandom_range(1, 6) : $urandom_range(0, 6);
      scenario(m, np, pick_lat(), pick_lat(), 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
